// File: rtl/seg7_pkg.sv
// seg7_pkg: BCD digit width, active-low gfedcba segment codes and the
// nibble-to-segment decoder shared by the counter/display blocks.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input logic [DIGIT_W-1:0] nibble);
        case (nibble)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: N-digit decimal up/down counter with saturating
// synchronous load and a one-cycle wrap pulse on over/underflow.
module bcd_updown_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          step,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          wrap
);

    logic [DIGIT_W*NUM_DIGITS-1:0] next_count;
    logic [DIGIT_W*NUM_DIGITS-1:0] sat_val;
    logic [DIGIT_W-1:0]            d;
    logic [DIGIT_W-1:0]            l;
    logic                          carry;

    // carry doubles as borrow; surviving past the top digit means wrap
    always_comb begin
        next_count = count;
        sat_val    = load_val;
        carry      = 1'b1;
        d          = '0;
        l          = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = count[i*DIGIT_W +: DIGIT_W];
            l = load_val[i*DIGIT_W +: DIGIT_W];
            sat_val[i*DIGIT_W +: DIGIT_W] = l > 4'd9 ? 4'd9 : l;
            next_count[i*DIGIT_W +: DIGIT_W] = !carry ? d :
                up_dn ? (d == 4'd9 ? 4'd0 : d + 4'd1) :
                        (d == 4'd0 ? 4'd9 : d - 4'd1);
            carry = carry && (up_dn ? d == 4'd9 : d == 4'd0);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            count <= sat_val;
            wrap  <= 1'b0;
        end else if (step) begin
            count <= next_count;
            wrap  <= carry;
        end else begin
            wrap  <= 1'b0;
        end
    end

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// bcd_counter_7seg_mux: prescaled N-digit BCD counter driving a multiplexed
// active-low 7-segment display with digit limit and leading-zero blanking.
module bcd_counter_7seg_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100_000_000,
    parameter int REFRESH_DIV = 100_000,
    parameter int SELW        = $clog2(NUM_DIGITS + 1)
) (
    input  logic                          clk_in,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val,
    input  logic [SELW-1:0]               sel_an,
    input  logic                          blank_lz,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [DIGIT_W*NUM_DIGITS-1:0] count,
    output logic                          wrap
);

    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    logic [PW-1:0]         presc;
    logic [RW-1:0]         rcnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  scan_step;
    logic                  lit;
    logic                  lz;
    int                    k;
    logic [DIGIT_W-1:0]    digit;
    logic [6:0]            seg_d;
    logic [NUM_DIGITS-1:0] an_d;

    assign tick      = presc == PW'(TICK_DIV - 1);
    assign scan_step = rcnt == RW'(REFRESH_DIV - 1);

    bcd_updown_counter #(.NUM_DIGITS(NUM_DIGITS)) u_counter (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .step     (tick && en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            rcnt  <= '0;
            idx   <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            rcnt  <= scan_step ? '0 : rcnt + 1'b1;
            if (scan_step)
                idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
        end
    end

    // a digit is a leading zero when it and every lit digit above it are zero
    always_comb begin
        k     = int'(sel_an) > NUM_DIGITS ? NUM_DIGITS : int'(sel_an);
        lit   = int'(idx) < k;
        digit = count[idx*DIGIT_W +: DIGIT_W];
        lz    = blank_lz && idx != '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (i >= int'(idx) && i < k && count[i*DIGIT_W +: DIGIT_W] != '0)
                lz = 1'b0;
        seg_d = lit && !lz ? bcd_to_seg(digit) : SEG_BLANK;
        an_d  = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_d;
            an  <= an_d;
        end
    end

endmodule

// File: tb/tb_bcd_counter_7seg_mux.sv
// tb_bcd_counter_7seg_mux: directed vectors for counting, load, wrap,
// digit limit and blanking with NUM_DIGITS=4, TICK_DIV=4, REFRESH_DIV=2.
module tb_bcd_counter_7seg_mux;

    logic        clk_in   = 1'b0;
    logic        rst_n    = 1'b0;
    logic        en       = 1'b1;
    logic        up_dn    = 1'b1;
    logic        load     = 1'b0;
    logic        blank_lz = 1'b0;
    logic [15:0] load_val = '0;
    logic [2:0]  sel_an   = 3'd4;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] count;
    logic        wrap;

    int checks = 0;
    int errors = 0;
    int e      = 0;

    typedef struct {
        logic [15:0] lv;
        logic [2:0]  sel;
        logic        blz;
        int          slot;
        logic [3:0]  an;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_in = ~clk_in;

    bcd_counter_7seg_mux #(
        .NUM_DIGITS  (4),
        .TICK_DIV    (4),
        .REFRESH_DIV (2)
    ) dut (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .sel_an   (sel_an),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .count    (count),
        .wrap     (wrap)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // e counts edges since reset release; prescaler = e%4, tick on edges with e%4==0
    task automatic clk1();
        @(posedge clk_in);
        e++;
        #1;
    endtask

    task automatic run_to_tick();
        for (int i = 0; i < 4; i++) begin
            clk1();
            if (e % 4 == 0) break;
        end
    endtask

    task automatic align_tick_next();
        for (int i = 0; i < 4 && e % 4 != 3; i++) clk1();
    endtask

    task automatic load_now(input logic [15:0] v);
        if (e % 4 == 3) clk1();
        load     = 1'b1;
        load_val = v;
        clk1();
        load     = 1'b0;
    endtask

    function automatic void add(input logic [15:0] lv, input logic [2:0] sel, input logic blz,
                                input int slot, input logic [3:0] a, input logic [6:0] s);
        vec_t v;
        v = '{lv, sel, blz, slot, a, s};
        vecs.push_back(v);
    endfunction

    initial begin
        add(16'h1234, 3'd4, 1'b0, 0, 4'hE, 7'b0011001);
        add(16'h1234, 3'd4, 1'b0, 1, 4'hD, 7'b0110000);
        add(16'h1234, 3'd4, 1'b0, 2, 4'hB, 7'b0100100);
        add(16'h1234, 3'd4, 1'b0, 3, 4'h7, 7'b1111001);
        add(16'h1234, 3'd2, 1'b0, 0, 4'hE, 7'b0011001);
        add(16'h1234, 3'd2, 1'b0, 1, 4'hD, 7'b0110000);
        add(16'h1234, 3'd2, 1'b0, 2, 4'hF, 7'h7F);
        add(16'h1234, 3'd2, 1'b0, 3, 4'hF, 7'h7F);
        add(16'h1234, 3'd0, 1'b0, 0, 4'hF, 7'h7F);
        add(16'h1234, 3'd0, 1'b0, 3, 4'hF, 7'h7F);
        add(16'h1234, 3'd7, 1'b0, 3, 4'h7, 7'b1111001);
        add(16'h0040, 3'd4, 1'b1, 0, 4'hE, 7'b1000000);
        add(16'h0040, 3'd4, 1'b1, 1, 4'hD, 7'b0011001);
        add(16'h0040, 3'd4, 1'b1, 2, 4'hB, 7'h7F);
        add(16'h0040, 3'd4, 1'b1, 3, 4'h7, 7'h7F);
        add(16'h0040, 3'd4, 1'b0, 2, 4'hB, 7'b1000000);
        add(16'h0040, 3'd4, 1'b0, 3, 4'h7, 7'b1000000);
        add(16'h0000, 3'd4, 1'b1, 0, 4'hE, 7'b1000000);
        add(16'h0000, 3'd4, 1'b1, 1, 4'hD, 7'h7F);
        add(16'h0040, 3'd2, 1'b1, 1, 4'hD, 7'b0011001);
        add(16'h0400, 3'd2, 1'b1, 1, 4'hD, 7'h7F);
        add(16'h0400, 3'd2, 1'b1, 0, 4'hE, 7'b1000000);

        for (int i = 0; i < 5; i++) begin
            clk1();
            chk("rst_count", count, 16'h0000);
            chk("rst_an", an, 4'hF);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_wrap", wrap, 1'b0);
        end
        rst_n = 1'b1;
        e     = 0;
        clk1();
        chk("first_an", an, 4'hE);
        chk("first_seg", seg, 7'b1000000);

        load_now(16'h9998);
        chk("up_load_count", count, 16'h9998);
        chk("up_load_wrap", wrap, 1'b0);
        run_to_tick();
        chk("up_9999", count, 16'h9999);
        chk("up_9999_wrap", wrap, 1'b0);
        run_to_tick();
        chk("up_wrap_count", count, 16'h0000);
        chk("up_wrap_pulse", wrap, 1'b1);
        clk1();
        chk("up_wrap_clear", wrap, 1'b0);
        chk("up_wrap_hold", count, 16'h0000);

        up_dn = 1'b0;
        load_now(16'h1000);
        run_to_tick();
        chk("dn_borrow", count, 16'h0999);
        chk("dn_borrow_wrap", wrap, 1'b0);
        load_now(16'h0000);
        run_to_tick();
        chk("dn_wrap_count", count, 16'h9999);
        chk("dn_wrap_pulse", wrap, 1'b1);
        clk1();
        chk("dn_wrap_clear", wrap, 1'b0);

        up_dn = 1'b1;
        align_tick_next();
        load     = 1'b1;
        load_val = 16'h12F4;
        clk1();
        load     = 1'b0;
        chk("prio_count", count, 16'h1294);
        chk("prio_wrap", wrap, 1'b0);
        clk1(); clk1(); clk1();
        chk("prio_hold", count, 16'h1294);
        run_to_tick();
        chk("prio_next", count, 16'h1295);

        align_tick_next();
        load     = 1'b1;
        load_val = 16'h9999;
        clk1();
        load     = 1'b0;
        chk("load_tick_count", count, 16'h9999);
        chk("load_tick_wrap", wrap, 1'b0);

        en = 1'b0;
        run_to_tick();
        chk("en_low_count", count, 16'h9999);
        chk("en_low_wrap", wrap, 1'b0);

        foreach (vecs[j]) begin
            load     = 1'b1;
            load_val = vecs[j].lv;
            clk1();
            load     = 1'b0;
            sel_an   = vecs[j].sel;
            blank_lz = vecs[j].blz;
            clk1();
            for (int i = 0; i < 8 && ((e - 1) / 2) % 4 != vecs[j].slot; i++) clk1();
            chk($sformatf("disp%0d_count", j), count, vecs[j].lv);
            chk($sformatf("disp%0d_an", j), an, vecs[j].an);
            chk($sformatf("disp%0d_seg", j), seg, vecs[j].seg);
        end

        en       = 1'b1;
        sel_an   = 3'd4;
        blank_lz = 1'b0;
        load_now(16'h5678);
        clk1();
        @(posedge clk_in);
        #2 rst_n = 1'b0;
        #1;
        chk("async_count", count, 16'h0000);
        chk("async_an", an, 4'hF);
        chk("async_seg", seg, 7'h7F);
        chk("async_wrap", wrap, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
